banco_reg_param: RTL and testbench
==================================

Name: banco_reg_param

Overview:
- Parametrised successor to the 3-entry calculator register bank.
- Single-edge (posedge `Clock`) design with these additions:
  - configurable width and depth;
  - registered dual read ports with a valid strobe;
  - write-to-read bypass;
  - optional hardwired-zero register 0;
  - sequential clear engine that zeroes the array one entry per cycle.
- Sits between the control FSM and the ALU/accumulator path.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 4, number of registers (≥2).
- AW, $clog2(DEPTH), address width (derived; not overridden).
- ZERO_REG, 0, if 1 then register 0 reads 0 and ignores writes.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Clear  in  1  request to zero all registers via clear engine.
- Busy  out  1  high while clear engine runs; reads and writes ignored.
- WrEn  in  1  write enable.
- WrAddr  in  AW  write address.
- WrData  in  WIDTH  write data.
- RdEn  in  1  read request for both ports.
- RdAddr1  in  AW  read address port 1.
- RdAddr2  in  AW  read address port 2.
- RdData1  out  WIDTH  registered read data port 1.
- RdData2  out  WIDTH  registered read data port 2.
- RdValid  out  1  one-cycle pulse: RdData1/2 updated this cycle.

Behaviour:
- Reset is synchronous, active-high, on `Clock` rising edge.
- On Reset:
  - RdData1 = RdData2 = 0, RdValid = 0;
  - FSM enters CLEAR with ClrIdx = 0 and Busy = 1.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states:
  - CLEAR, Busy = 1:
    - each cycle writes 0 to reg[ClrIdx] and increments ClrIdx;
    - when ClrIdx == DEPTH-1 is written, next state is IDLE.
    - Total duration is exactly DEPTH cycles after Reset deasserts.
  - IDLE, Busy = 0: normal operation.
    - Clear = 1 → CLEAR with ClrIdx = 0, starting next cycle.
    - In the cycle Clear is sampled, WrEn and RdEn are still honoured.
- Clear = 1 during CLEAR restarts ClrIdx at 0 (clear extends).
- Reset during CLEAR restarts the clear from 0.
- Busy is a registered output: Busy = (state == CLEAR).
- During CLEAR:
  - WrEn and RdEn are ignored and RdValid = 0;
  - RdData1/2 hold their values.
- Write, IDLE, WrEn = 1: reg[WrAddr] ← WrData at the rising edge.
  - WrAddr ≥ DEPTH: write dropped.
  - ZERO_REG = 1 and WrAddr = 0: write dropped.
- Read, IDLE, RdEn = 1: one-cycle latency.
  - At the edge, RdDataN ← value(RdAddrN) and RdValid ← 1.
  - RdEn = 0: RdValid ← 0 and RdDataN hold.
- value(a) resolves in this priority order:
  1. ZERO_REG = 1 and a = 0 → 0.
  2. a ≥ DEPTH → 0.
  3. WrEn = 1 in the same cycle, write not dropped, and WrAddr == a → WrData (bypass, new value).
  4. Otherwise → reg[a].
- Both ports may address the same register; both return the same value.
- No X is ever driven on the outputs after the first Reset edge.

Decomposition:
- Shared package `banco_reg_pkg`:
  - FSM state enum (ST_IDLE, ST_CLEAR);
  - localparams for the default WIDTH/DEPTH;
  - a register-ID constants list (REG_FONTE_A = 0, REG_FONTE_B = 1, REG_ACUM = 2) reused by the control FSM.
- Sub-module `banco_reg_clr_ctrl`: the clear FSM plus ClrIdx counter.
  - Outputs: Busy, clr_we, clr_idx.
- The top level holds the array, the write mux (clear vs user), the bypass and the read registers.

Test Plan:
- Reset for 1 cycle, then release:
  - Busy = 1 for exactly 4 cycles (DEPTH = 4), then 0;
  - RdValid stays 0 throughout;
  - reading addresses 0..3 afterwards returns 0x00000000 on both ports.
- Write 0xDEADBEEF to addr 1; next cycle RdEn with RdAddr1 = 1, RdAddr2 = 1:
  - one cycle later both RdData = 0xDEADBEEF and RdValid pulses for 1 cycle.
- Same cycle: WrEn to addr 2 with 0x12345678, RdEn with RdAddr1 = 2, RdAddr2 = 0 (reg0 holds 0x5):
  - next cycle RdData1 = 0x12345678 (bypass) and RdData2 = 0x5.
- ZERO_REG = 1: write 0xFFFFFFFF to addr 0, then read addr 0:
  - returns 0.
- DEPTH = 3 build: write to addr 3, then read addr 3:
  - returns 0; regs 0..2 are unchanged.
- Fill regs with nonzero values, pulse Clear, then pulse Clear again 2 cycles into CLEAR:
  - Busy stays high for 2 + 4 cycles total;
  - a WrEn issued during Busy is ignored;
  - all regs read 0 afterwards.

Source files
------------

// File: rtl/banco_reg_pkg.sv
// Shared definitions for the parametrised register bank and the control FSM that drives it.
package banco_reg_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // Register IDs used by the calculator control FSM
  localparam int REG_FONTE_A = 0;
  localparam int REG_FONTE_B = 1;
  localparam int REG_ACUM    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/banco_reg_param_if.sv
// Request/response bundle between the control FSM (master) and the register bank (slave).
interface banco_reg_param_if
  import banco_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             Clear;
  logic             Busy;
  logic             WrEn;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic             RdEn;
  logic [AW-1:0]    RdAddr1;
  logic [AW-1:0]    RdAddr2;
  logic [WIDTH-1:0] RdData1;
  logic [WIDTH-1:0] RdData2;
  logic             RdValid;

  modport master (
    output Clear, WrEn, WrAddr, WrData, RdEn, RdAddr1, RdAddr2,
    input  Busy, RdData1, RdData2, RdValid
  );

  modport slave (
    input  Clear, WrEn, WrAddr, WrData, RdEn, RdAddr1, RdAddr2,
    output Busy, RdData1, RdData2, RdValid
  );

endinterface

// File: rtl/banco_reg_clr_ctrl.sv
// Clear engine: walks clr_idx over every entry, one per cycle, restarting on Reset or Clear.
module banco_reg_clr_ctrl
  import banco_reg_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Clear,
  output logic          Busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (Clear) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // A new Clear request restarts the sweep rather than finishing the current one
        if (Clear) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign Busy    = (r_state == ST_CLEAR);
  assign clr_we  = Busy;
  assign clr_idx = r_idx;

endmodule

// File: rtl/banco_reg_param.sv
// Parametrised register bank: user/clear write mux, write-to-read bypass and dual registered read ports.
module banco_reg_param
  import banco_reg_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input logic              Clock,
  input logic              Reset,
  banco_reg_param_if.slave bus
);

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_idx;
  logic             w_wr_ok;
  logic             w_rd_go;
  logic [WIDTH-1:0] w_val1_p0;
  logic [WIDTH-1:0] w_val2_p0;

  logic [WIDTH-1:0] r_rd1_p1;
  logic [WIDTH-1:0] r_rd2_p1;
  logic             r_vld_p1;

  banco_reg_clr_ctrl #(.DEPTH(DEPTH)) u_clr_ctrl (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (bus.Clear),
    .Busy    (w_busy),
    .clr_we  (w_clr_we),
    .clr_idx (w_clr_idx)
  );

  // Address names a real, writable register (not past the end, not the hardwired zero)
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] rd_value(input logic [AW-1:0] a,
                                                input logic          wr_ok,
                                                input logic [AW-1:0] wr_addr,
                                                input logic [WIDTH-1:0] wr_data,
                                                input logic [WIDTH-1:0] stored);
    if (!addr_live(a))              return '0;
    if (wr_ok && (wr_addr == a))    return wr_data;
    return stored;
  endfunction

  assign w_wr_ok = bus.WrEn && !w_busy && !Reset && addr_live(bus.WrAddr);
  assign w_rd_go = bus.RdEn && !w_busy;

  // Stage p0: resolve both read addresses, bypassing the write landing this edge
  always_comb begin
    w_val1_p0 = rd_value(bus.RdAddr1, w_wr_ok, bus.WrAddr, bus.WrData, r_mem[bus.RdAddr1]);
    w_val2_p0 = rd_value(bus.RdAddr2, w_wr_ok, bus.WrAddr, bus.WrData, r_mem[bus.RdAddr2]);
  end

  always_ff @(posedge Clock) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.WrAddr] <= bus.WrData;
    end
  end

  // Stage p1: registered read data; holds when no read is accepted
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd1_p1 <= '0;
      r_rd2_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_go;
      if (w_rd_go) begin
        r_rd1_p1 <= w_val1_p0;
        r_rd2_p1 <= w_val2_p0;
      end
    end
  end

  assign bus.Busy    = w_busy;
  assign bus.RdData1 = r_rd1_p1;
  assign bus.RdData2 = r_rd2_p1;
  assign bus.RdValid = r_vld_p1;

endmodule

// File: tb/tb_banco_reg_param.sv
// Drives three register-bank builds (4 deep, 4 deep with zero reg, 3 deep) with shared stimulus.
module tb_banco_reg_param;
  import banco_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        t_clr = 1'b0;
  logic        t_we  = 1'b0;
  logic        t_re  = 1'b0;
  logic [1:0]  t_wa  = '0;
  logic [1:0]  t_ra1 = '0;
  logic [1:0]  t_ra2 = '0;
  logic [31:0] t_wd  = '0;

  banco_reg_param_if #(.WIDTH(32), .DEPTH(4)) bus0 ();
  banco_reg_param_if #(.WIDTH(32), .DEPTH(4)) bus1 ();
  banco_reg_param_if #(.WIDTH(32), .DEPTH(3)) bus2 ();

  assign {bus0.Clear, bus0.WrEn, bus0.WrAddr, bus0.WrData, bus0.RdEn, bus0.RdAddr1, bus0.RdAddr2} =
         {t_clr, t_we, t_wa, t_wd, t_re, t_ra1, t_ra2};
  assign {bus1.Clear, bus1.WrEn, bus1.WrAddr, bus1.WrData, bus1.RdEn, bus1.RdAddr1, bus1.RdAddr2} =
         {t_clr, t_we, t_wa, t_wd, t_re, t_ra1, t_ra2};
  assign {bus2.Clear, bus2.WrEn, bus2.WrAddr, bus2.WrData, bus2.RdEn, bus2.RdAddr1, bus2.RdAddr2} =
         {t_clr, t_we, t_wa, t_wd, t_re, t_ra1, t_ra2};

  banco_reg_param #(.WIDTH(32), .DEPTH(4), .ZERO_REG(0)) dut0 (.Clock(clk), .Reset(rst), .bus(bus0));
  banco_reg_param #(.WIDTH(32), .DEPTH(4), .ZERO_REG(1)) dut1 (.Clock(clk), .Reset(rst), .bus(bus1));
  banco_reg_param #(.WIDTH(32), .DEPTH(3), .ZERO_REG(0)) dut2 (.Clock(clk), .Reset(rst), .bus(bus2));

  logic [31:0] o_rd1  [3];
  logic [31:0] o_rd2  [3];
  logic        o_vld  [3];
  logic        o_busy [3];
  assign o_rd1[0] = bus0.RdData1;  assign o_rd2[0] = bus0.RdData2;
  assign o_vld[0] = bus0.RdValid;  assign o_busy[0] = bus0.Busy;
  assign o_rd1[1] = bus1.RdData1;  assign o_rd2[1] = bus1.RdData2;
  assign o_vld[1] = bus1.RdValid;  assign o_busy[1] = bus1.Busy;
  assign o_rd1[2] = bus2.RdData1;  assign o_rd2[2] = bus2.RdData2;
  assign o_vld[2] = bus2.RdValid;  assign o_busy[2] = bus2.Busy;

  // Reference model: contents, last read data, and cycles of clearing still to go
  logic [31:0] m_mem  [3][4];
  logic [31:0] m_rd1  [3];
  logic [31:0] m_rd2  [3];
  logic        m_vld  [3];
  int          m_left [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic int dep(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic bit zr(input int d);
    return d == 1;
  endfunction

  function automatic bit wr_ok(input int d);
    return t_we && (int'(t_wa) < dep(d)) && !(zr(d) && t_wa == 2'd0);
  endfunction

  function automatic logic [31:0] val(input int d, input logic [1:0] a);
    if (zr(d) && a == 2'd0)       return 32'h0;
    if (int'(a) >= dep(d))        return 32'h0;
    if (wr_ok(d) && t_wa == a)    return t_wd;
    return m_mem[d][a];
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_rd1[d] = '0; m_rd2[d] = '0; m_vld[d] = 1'b0; m_left[d] = dep(d);
        for (int k = 0; k < 4; k++) m_mem[d][k] = '0;
      end else if (m_left[d] > 0) begin
        m_vld[d]  = 1'b0;
        m_left[d] = t_clr ? dep(d) : m_left[d] - 1;
      end else begin
        m_vld[d] = t_re;
        if (t_re) begin
          m_rd1[d] = val(d, t_ra1);
          m_rd2[d] = val(d, t_ra2);
        end
        if (wr_ok(d)) m_mem[d][t_wa] = t_wd;
        if (t_clr) begin
          m_left[d] = dep(d);
          for (int k = 0; k < 4; k++) m_mem[d][k] = '0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit we, input logic [1:0] wa,
                       input logic [31:0] wd, input bit re, input logic [1:0] a1,
                       input logic [1:0] a2);
    @(negedge clk);
    rst = r; t_clr = c; t_we = we; t_wa = wa; t_wd = wd; t_re = re; t_ra1 = a1; t_ra2 = a2;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("c%0d.dut%0d.busy", cyc, d), 32'(o_busy[d]), 32'(m_left[d] > 0));
      chk($sformatf("c%0d.dut%0d.vld",  cyc, d), 32'(o_vld[d]),  32'(m_vld[d]));
      chk($sformatf("c%0d.dut%0d.rd1",  cyc, d), o_rd1[d], m_rd1[d]);
      chk($sformatf("c%0d.dut%0d.rd2",  cyc, d), o_rd2[d], m_rd2[d]);
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 2'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(0, 0, 1, a, d, 0, 2'd0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] a1, input logic [1:0] a2);
    cycle(0, 0, 0, 2'd0, 32'h0, 1, a1, a2);
  endtask

  initial begin
    cycle(1, 0, 0, 2'd0, 32'h0, 0, 2'd0, 2'd0);
    repeat (5) idle();
    rd(2'd0, 2'd1);
    rd(2'd2, 2'd3);

    wr(2'd1, 32'hDEADBEEF);
    rd(2'd1, 2'd1);
    idle();

    wr(2'd0, 32'h00000005);
    cycle(0, 0, 1, 2'd2, 32'h12345678, 1, 2'd2, 2'd0);
    idle();

    wr(2'd0, 32'hFFFFFFFF);
    rd(2'd0, 2'd0);

    wr(2'd3, 32'hA5A5A5A5);
    rd(2'd3, 2'd0);
    rd(2'd1, 2'(REG_ACUM));

    for (int i = 0; i < 4; i++) wr(2'(i), 32'h1000 + 32'(i) + 32'h1);
    cycle(0, 1, 0, 2'd0, 32'h0, 0, 2'd0, 2'd0);
    idle();
    cycle(0, 1, 0, 2'd0, 32'h0, 0, 2'd0, 2'd0);
    cycle(0, 0, 1, 2'd1, 32'h00000BAD, 1, 2'd1, 2'd1);
    repeat (5) idle();
    rd(2'd0, 2'd1);
    rd(2'd2, 2'd3);

    cycle(1, 0, 0, 2'd0, 32'h0, 0, 2'd0, 2'd0);
    repeat (4) idle();

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 100) == 0, ($urandom % 40) == 0, 1'($urandom), 2'($urandom),
            $urandom, 1'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
